multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Parametrised multicycle MIPS control unit: full fetch/decode/execute FSM driving the datapath mux/enable signals.
//  Memory latency (wait states) is a parameter. Decodes R-type add/sub/and/xor/slt plus lw, sw, beq, j and addi.
//  Sits between instruction register (opcode/funct) and datapath; all outputs fully defined (no x) in every state.
// PARAMETERS
//  MEM_WAIT  2  wait cycles after each memory access cycle; legal 1..15
// PORTS
//  clock         in   1  single clock, rising edge
//  reset         in   1  asynchronous, active-low (0 = reset)
//  Opcode        in   6  IR[31:26]
//  Funct         in   6  IR[5:0]
//  Zero          in   1  ALU zero flag (beq)
//  PCWriteCond   out  1  PC write when Zero=1
//  PCWrite       out  1  unconditional PC write
//  IorD          out  1  0=PC addr, 1=ALUOut addr
//  MemReadWrite  out  1  0=read, 1=write
//  MemtoReg      out  1  1=MDR to reg file
//  IRWrite       out  1  load IR
//  AluSrcA       out  1  0=PC, 1=A
//  RegWrite      out  1  reg file write
//  RegDst        out  1  0=rt, 1=rd
//  AWrite/BWrite out  1  load A/B regs
//  ExcFlag       out  1  illegal opcode trapped (0 unless CTRL_EXCEPTION_EN)
//  PCSource      out  2  00=ALU, 01=ALUOut, 10=jump target, 11=exception vector
//  AluSrcB       out  2  00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
//  ALUOpOut      out  3  alu_op_t: LOAD,ADD,SUB,AND,INC,NEG,XOR,COMP
//  State_out     out  4  current state_t encoding (debug)
// BEHAVIOUR
//  Reset: state=FETCH, wait counter=0; all outputs 0 except those FETCH drives. Reset mid-instruction aborts immediately.
//  Default every state: all enables 0, MemReadWrite=0, muxes 0, ALUOp=ADD; states override only listed signals.
//  ALUOut register loads every cycle (datapath).
//  FETCH: IorD=0, PCWrite=1, AluSrcB=01, ADD -> FETCH_WAIT.
//  FETCH_WAIT: MEM_WAIT cycles; IRWrite=1 on last cycle only -> DECODE.
//  DECODE: AWrite=BWrite=1, AluSrcB=11, ADD (branch target). Next by Opcode:
//   0x00 R_EXEC; 0x23/0x2B/0x08 MEM_ADDR (addi too); 0x04 BRANCH; 0x02 JUMP; other ILLEGAL.
//  MEM_ADDR: AluSrcA=1, AluSrcB=10, ADD -> MEM_RD (lw), MEM_WR (sw), ADDI_WB (addi).
//  MEM_RD: IorD=1, read; 1 + MEM_WAIT cycles -> MEM_WB. MEM_WB: MemtoReg=1, RegWrite=1, RegDst=0 -> FETCH.
//  MEM_WR: IorD=1, MemReadWrite=1 held 1 + MEM_WAIT cycles -> FETCH.
//  ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
//  R_EXEC: AluSrcA=1, AluSrcB=00; Funct 0x20 ADD,0x22 SUB,0x24 AND,0x26 XOR,0x2A COMP, else ADD -> R_WB.
//  R_WB: RegWrite=1, RegDst=1, ALUOp held -> FETCH.
//  BRANCH: AluSrcA=1, SUB, PCWriteCond=1, PCSource=01 -> FETCH. JUMP: PCWrite=1, PCSource=10 -> FETCH.
//  Cycles/instr (W=MEM_WAIT): R 4+W, addi 4+W, lw 5+2W, sw 4+2W, beq/j 3+W.
//  Wait counter: $clog2(MEM_WAIT+1) bits, cleared on entry to any wait phase, never wraps (saturating compare).
// CONFIGURATION
//  CTRL_EXCEPTION_EN defined: ILLEGAL state 1 cycle, PCWrite=1, PCSource=11, ExcFlag=1 -> FETCH.
//  Not defined: ILLEGAL state absent; illegal opcode DECODE -> FETCH (NOP); ExcFlag tied 0.
// STRUCTURE
//  Package control_pkg: state_t (4-bit enum), alu_op_t (3-bit enum), OP_*/FN_* localparams, STATE_W=4.
//  Sub-module mem_wait_counter #(MEM_WAIT): inputs clock, reset, clear, enable; output done.
// TESTING
//  reset low mid-lw (MEM_RD) -> next cycle State_out=FETCH, PCWrite=1, RegWrite=0.
//  MEM_WAIT=2, Opcode=0x00 Funct=0x22 -> SUB in R_EXEC, RegWrite=1 RegDst=1 at cycle 6, FETCH at 7.
//  MEM_WAIT=2, lw 0x23 -> IRWrite only at cycle 3, IorD=1 for 3 cycles, MemtoReg=RegWrite=1 at cycle 9.
//  sw 0x2B, MEM_WAIT=1 -> MemReadWrite=1 for exactly 2 cycles, RegWrite never 1.
//  beq Zero=0 / Zero=1 -> PCWriteCond=1, PCSource=01 one cycle; j -> PCSource=10, PCWrite=1.
//  Opcode=0x3F: with CTRL_EXCEPTION_EN ExcFlag=1, PCSource=11 one cycle; without, DECODE->FETCH, ExcFlag=0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
//   state_t  : 4-bit FSM state encoding, also exported on State_out
//   alu_op_t : 3-bit ALU operation code driven on ALUOpOut
//   OP_* / FN_* : decoded opcode and R-type funct values
//   funct_to_alu : R-type funct field to ALU operation
package control_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH      = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_MEM_ADDR   = 4'd3,
    S_MEM_RD     = 4'd4,
    S_MEM_WB     = 4'd5,
    S_MEM_WR     = 4'd6,
    S_ADDI_WB    = 4'd7,
    S_R_EXEC     = 4'd8,
    S_R_WB       = 4'd9,
    S_BRANCH     = 4'd10,
    S_JUMP       = 4'd11,
    S_ILLEGAL    = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    ALU_LOAD = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_INC  = 3'd4,
    ALU_NEG  = 3'd5,
    ALU_XOR  = 3'd6,
    ALU_COMP = 3'd7
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Unrecognised funct codes fall back to ADD so R_EXEC never produces x.
  function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
    alu_op_t op;
    case (funct)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_XOR:  op = ALU_XOR;
      FN_SLT:  op = ALU_COMP;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory wait-phase counter for the multicycle control unit.
// Counts the cycles of a memory phase starting at the access cycle; done is
// high once MEM_WAIT cycles have followed the access cycle. The count
// saturates at MEM_WAIT instead of wrapping.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset, clears the count
//   clear  : synchronous clear, wins over enable
//   enable : advance the count this cycle
//   done   : count has reached MEM_WAIT
module mem_wait_counter #(
  parameter int MEM_WAIT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: fetch/decode/execute FSM that drives the
// datapath mux selects and register enables. Decodes R-type add/sub/and/
// xor/slt, lw, sw, addi, beq and j. MEM_WAIT (1..15) sets the number of wait
// cycles following every memory access cycle.
// Optional feature: define CTRL_EXCEPTION_EN to trap illegal opcodes in a
// one-cycle ILLEGAL state (PC <- exception vector, ExcFlag=1). Without it an
// illegal opcode returns from DECODE straight to FETCH and ExcFlag stays 0.
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   Opcode, Funct         : IR[31:26], IR[5:0]
//   Zero                  : ALU zero flag (combined with PCWriteCond in datapath)
//   PCWriteCond, PCWrite  : conditional / unconditional PC write
//   IorD, MemReadWrite    : memory address select, 0=read 1=write
//   MemtoReg, IRWrite     : write-back source select, IR load
//   AluSrcA, AluSrcB      : ALU operand selects
//   RegWrite, RegDst      : register file write enable, destination select
//   AWrite, BWrite        : A/B operand register loads
//   ExcFlag               : illegal opcode trapped
//   PCSource              : next-PC select
//   ALUOpOut              : alu_op_t operation
//   State_out             : current state encoding (debug)
module multicycle_control_fsm
  import control_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemReadWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       AluSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       AWrite,
  output logic       BWrite,
  output logic       ExcFlag,
  output logic [1:0] PCSource,
  output logic [1:0] AluSrcB,
  output logic [2:0] ALUOpOut,
  output logic [3:0] State_out
);

  state_t  state_q;
  state_t  state_d;
  alu_op_t alu_op;
  logic    wait_clear;
  logic    wait_en;
  logic    wait_done;

  // The branch decision (PCWriteCond & Zero) is formed in the datapath.
  logic    zero_unused;
  assign zero_unused = Zero;

  // A memory phase starts at its access cycle: FETCH for instruction fetch,
  // the first MEM_RD/MEM_WR cycle for data. The counter restarts whenever
  // one of those states is newly entered and runs through the phase.
  assign wait_clear = (state_d != state_q) &&
                      (state_d inside {S_FETCH, S_MEM_RD, S_MEM_WR});
  assign wait_en    = state_q inside {S_FETCH, S_FETCH_WAIT, S_MEM_RD, S_MEM_WR};

  mem_wait_counter #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clock (clock),
    .reset (reset),
    .clear (wait_clear),
    .enable(wait_en),
    .done  (wait_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    PCWriteCond  = 1'b0;
    PCWrite      = 1'b0;
    IorD         = 1'b0;
    MemReadWrite = 1'b0;
    MemtoReg     = 1'b0;
    IRWrite      = 1'b0;
    AluSrcA      = 1'b0;
    RegWrite     = 1'b0;
    RegDst       = 1'b0;
    AWrite       = 1'b0;
    BWrite       = 1'b0;
    ExcFlag      = 1'b0;
    PCSource     = 2'b00;
    AluSrcB      = 2'b00;
    alu_op       = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        PCWrite = 1'b1;
        AluSrcB = 2'b01;
        state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (wait_done) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively while A/B load.
        AWrite  = 1'b1;
        BWrite  = 1'b1;
        AluSrcB = 2'b11;
        case (Opcode)
          OP_RTYPE:              state_d = S_R_EXEC;
          OP_LW, OP_SW, OP_ADDI: state_d = S_MEM_ADDR;
          OP_BEQ:                state_d = S_BRANCH;
          OP_J:                  state_d = S_JUMP;
`ifdef CTRL_EXCEPTION_EN
          default:               state_d = S_ILLEGAL;
`else
          default:               state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        case (Opcode)
          OP_LW:   state_d = S_MEM_RD;
          OP_SW:   state_d = S_MEM_WR;
          OP_ADDI: state_d = S_ADDI_WB;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_RD: begin
        IorD = 1'b1;
        if (wait_done) begin
          state_d = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        IorD         = 1'b1;
        MemReadWrite = 1'b1;
        if (wait_done) begin
          state_d = S_FETCH;
        end
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_R_EXEC: begin
        AluSrcA = 1'b1;
        alu_op  = funct_to_alu(Funct);
        state_d = S_R_WB;
      end
      S_R_WB: begin
        // ALU op stays on the R-type function through write-back.
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        alu_op   = funct_to_alu(Funct);
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        AluSrcA     = 1'b1;
        alu_op      = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
      end
`ifdef CTRL_EXCEPTION_EN
      S_ILLEGAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
        ExcFlag  = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign ALUOpOut  = alu_op;
  assign State_out = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;
  import control_pkg::*;

  localparam int MW = 2;

  // Control flag bit positions inside the expected/actual vector.
  localparam logic [11:0] F_PCWC = 12'h800;
  localparam logic [11:0] F_PCW  = 12'h400;
  localparam logic [11:0] F_IORD = 12'h200;
  localparam logic [11:0] F_MRW  = 12'h100;
  localparam logic [11:0] F_M2R  = 12'h080;
  localparam logic [11:0] F_IRW  = 12'h040;
  localparam logic [11:0] F_ASA  = 12'h020;
  localparam logic [11:0] F_RW   = 12'h010;
  localparam logic [11:0] F_RD   = 12'h008;
  localparam logic [11:0] F_AW   = 12'h004;
  localparam logic [11:0] F_BW   = 12'h002;
  localparam logic [11:0] F_EXC  = 12'h001;

  typedef struct {
    logic [22:0] v;
    int          id;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWriteCond, PCWrite, IorD, MemReadWrite, MemtoReg, IRWrite;
  logic       AluSrcA, RegWrite, RegDst, AWrite, BWrite, ExcFlag;
  logic [1:0] PCSource, AluSrcB;
  logic [2:0] ALUOpOut;
  logic [3:0] State_out;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          push_cnt = 0;
  int          instr_id = 0;
  logic        mon_en = 1'b0;
  logic [22:0] act;

  multicycle_control_fsm #(.MEM_WAIT(MW)) dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
    .MemReadWrite(MemReadWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .AluSrcA(AluSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .AWrite(AWrite), .BWrite(BWrite), .ExcFlag(ExcFlag),
    .PCSource(PCSource), .AluSrcB(AluSrcB), .ALUOpOut(ALUOpOut),
    .State_out(State_out)
  );

  always #5 clock = ~clock;

  assign act = {PCWriteCond, PCWrite, IorD, MemReadWrite, MemtoReg, IRWrite,
                AluSrcA, RegWrite, RegDst, AWrite, BWrite, ExcFlag,
                PCSource, AluSrcB, ALUOpOut, State_out};

  function automatic logic [22:0] mkv(input state_t s, input logic [11:0] fl,
                                      input logic [1:0] pcs, input logic [1:0] srcb,
                                      input alu_op_t op);
    return {fl, pcs, srcb, op, s};
  endfunction

  function automatic logic [22:0] fetch_vec();
    return mkv(S_FETCH, F_PCW, 2'b00, 2'b01, ALU_ADD);
  endfunction

  function automatic alu_op_t ref_alu(input logic [5:0] fn);
    if (fn == 6'h20) return ALU_ADD;
    if (fn == 6'h22) return ALU_SUB;
    if (fn == 6'h24) return ALU_AND;
    if (fn == 6'h26) return ALU_XOR;
    if (fn == 6'h2A) return ALU_COMP;
    return ALU_ADD;
  endfunction

  task automatic check(input string name, input logic [22:0] a, input logic [22:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d) at %0t",
               name, a, a[3:0], x, x[3:0], $time);
    end
  endtask

  task automatic push(input state_t s, input logic [11:0] fl, input logic [1:0] pcs,
                      input logic [1:0] srcb, input alu_op_t op);
    exp_t e;
    e.v = mkv(s, fl, pcs, srcb, op);
    e.id = instr_id;
    exp_q.push_back(e);
    push_cnt++;
  endtask

  // Reference model: one instruction as a list of phases, one entry per cycle.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, output int len);
    int start;
    start = push_cnt;
    push(S_FETCH, F_PCW, 2'b00, 2'b01, ALU_ADD);
    for (int i = 1; i <= MW; i++)
      push(S_FETCH_WAIT, (i == MW) ? F_IRW : 12'h000, 2'b00, 2'b00, ALU_ADD);
    push(S_DECODE, F_AW | F_BW, 2'b00, 2'b11, ALU_ADD);
    case (op)
      6'h00: begin
        push(S_R_EXEC, F_ASA, 2'b00, 2'b00, ref_alu(fn));
        push(S_R_WB, F_RW | F_RD, 2'b00, 2'b00, ref_alu(fn));
      end
      6'h23: begin
        push(S_MEM_ADDR, F_ASA, 2'b00, 2'b10, ALU_ADD);
        for (int i = 0; i <= MW; i++) push(S_MEM_RD, F_IORD, 2'b00, 2'b00, ALU_ADD);
        push(S_MEM_WB, F_M2R | F_RW, 2'b00, 2'b00, ALU_ADD);
      end
      6'h2B: begin
        push(S_MEM_ADDR, F_ASA, 2'b00, 2'b10, ALU_ADD);
        for (int i = 0; i <= MW; i++) push(S_MEM_WR, F_IORD | F_MRW, 2'b00, 2'b00, ALU_ADD);
      end
      6'h08: begin
        push(S_MEM_ADDR, F_ASA, 2'b00, 2'b10, ALU_ADD);
        push(S_ADDI_WB, F_RW, 2'b00, 2'b00, ALU_ADD);
      end
      6'h04: push(S_BRANCH, F_ASA | F_PCWC, 2'b01, 2'b00, ALU_SUB);
      6'h02: push(S_JUMP, F_PCW, 2'b10, 2'b00, ALU_ADD);
      default: begin
`ifdef CTRL_EXCEPTION_EN
        push(S_ILLEGAL, F_PCW | F_EXC, 2'b11, 2'b00, ALU_ADD);
`endif
      end
    endcase
    len = push_cnt - start;
  endtask

  // Called at posedge+1 of the cycle the DUT spends in FETCH.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int len;
    Opcode = op;
    Funct  = fn;
    Zero   = z;
    instr_id++;
    model_instr(op, fn, len);
    repeat (len) @(posedge clock);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a full control word.
  always @(negedge clock) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL underflow: got %h expected no output at %0t", act, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("instr%0d", mon_e.id), act, mon_e.v);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [5:0] op_tab[6] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h02};
  logic [5:0] fn_tab[5] = '{6'h20, 6'h22, 6'h24, 6'h26, 6'h2A};

  initial begin
    int len;
    logic [5:0] op;
    logic [5:0] fn;
    reset  = 1'b0;
    Opcode = 6'h00;
    Funct  = 6'h00;
    Zero   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", act, fetch_vec());
    reset  = 1'b1;
    mon_en = 1'b1;

    // Directed instructions
    issue(6'h00, 6'h22, 1'b0);   // sub
    issue(6'h23, 6'h00, 1'b0);   // lw
    issue(6'h2B, 6'h00, 1'b0);   // sw
    issue(6'h08, 6'h00, 1'b0);   // addi
    issue(6'h04, 6'h00, 1'b0);   // beq not taken
    issue(6'h04, 6'h00, 1'b1);   // beq taken
    issue(6'h02, 6'h00, 1'b0);   // j
    issue(6'h3F, 6'h00, 1'b0);   // illegal
    issue(6'h00, 6'h20, 1'b0);
    issue(6'h00, 6'h24, 1'b0);
    issue(6'h00, 6'h26, 1'b0);
    issue(6'h00, 6'h2A, 1'b0);
    issue(6'h00, 6'h11, 1'b0);   // unknown funct

    // Reset asserted in the middle of a load's memory read
    Opcode = 6'h23;
    Funct  = 6'h00;
    Zero   = 1'b0;
    instr_id++;
    model_instr(6'h23, 6'h00, len);
    repeat (MW + 4) @(posedge clock);
    #1;
    mon_en = 1'b0;
    check("lw_in_mem_rd", act, exp_q[0].v);
    exp_q.delete();
    #2;
    reset = 1'b0;
    #1;
    check("async_abort", act, fetch_vec());
    @(negedge clock);
    check("abort_next_cycle", act, fetch_vec());
    @(posedge clock);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    issue(6'h00, 6'h22, 1'b0);

    // Randomised instruction stream
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = op_tab[$urandom_range(0, 5)];
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
      else fn = fn_tab[$urandom_range(0, 4)];
      issue(op, fn, 1'($urandom));
    end

    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
